image_control: RTL and testbench

//  Consumer/reader side of the blur line-buffer path. Accepts the raster pixel stream and

---
 rtl/image_control.sv | 142 ++++++++++++++
 tb/tb_image_control.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/image_control.sv
// 3x3 window generator: 4 round-robin line buffers, one filling while three are read in lockstep.
// Zero-latency window output (prefetched buffer reads); no input backpressure, o_intr frees a line.

module line_buffer (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_data,
  input  logic        i_data_valid,
  input  logic        i_read_data,
  output logic [23:0] o_data
);
  logic [7:0] mem [512];
  logic [8:0] wr_ptr;
  logic [8:0] rd_ptr;
  logic [8:0] rd_ptr1;
  logic [8:0] rd_ptr2;

  always_ff @(posedge i_clk) begin
    if (i_data_valid) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (i_data_valid) wr_ptr <= wr_ptr + 9'd1;
      if (i_read_data)  rd_ptr <= rd_ptr + 9'd1;
    end
  end

  // Three consecutive pixels are presented combinationally; addresses wrap at the line end.
  assign rd_ptr1 = rd_ptr + 9'd1;
  assign rd_ptr2 = rd_ptr + 9'd2;
  assign o_data  = {mem[rd_ptr], mem[rd_ptr1], mem[rd_ptr2]};
endmodule

module image_control (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_pixel_data,
  input  logic        i_pixel_data_valid,
  output logic [71:0] o_pixel_data,
  output logic        o_pixel_data_valid,
  output logic        o_intr
);
  localparam int NUM_BUFS = 4;
  localparam logic [11:0] THREE_LINES = 12'd1536;

  typedef enum logic {IDLE, READ} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [8:0]  wr_cnt;
  logic [8:0]  rd_cnt;
  logic [1:0]  wr_sel;
  logic [1:0]  rd_sel;
  logic [1:0]  rd_sel1;
  logic [1:0]  rd_sel2;
  logic [11:0] total_cnt;
  logic        rd_en;
  logic        rd_last;
  logic [NUM_BUFS-1:0] buf_wr_vld;
  logic [NUM_BUFS-1:0] buf_rd;
  logic [23:0] buf_dat [NUM_BUFS];

  assign rd_en   = (state == READ);
  assign rd_last = rd_en && (rd_cnt == 9'd511);
  assign rd_sel1 = rd_sel + 2'd1;
  assign rd_sel2 = rd_sel + 2'd2;

  always_comb begin
    buf_wr_vld         = '0;
    buf_wr_vld[wr_sel] = i_pixel_data_valid;
    buf_rd             = '0;
    if (rd_en) begin
      buf_rd[rd_sel]  = 1'b1;
      buf_rd[rd_sel1] = 1'b1;
      buf_rd[rd_sel2] = 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_BUFS; g++) begin : g_buf
    line_buffer u_lb (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_data       (i_pixel_data),
      .i_data_valid (buf_wr_vld[g]),
      .i_read_data  (buf_rd[g]),
      .o_data       (buf_dat[g])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_cnt <= '0;
      wr_sel <= '0;
    end else if (i_pixel_data_valid) begin
      wr_cnt <= wr_cnt + 9'd1;
      if (wr_cnt == 9'd511) wr_sel <= wr_sel + 2'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      total_cnt <= '0;
    end else begin
      case ({i_pixel_data_valid, rd_en})
        2'b10:   total_cnt <= total_cnt + 12'd1;
        2'b01:   total_cnt <= total_cnt - 12'd1;
        default: total_cnt <= total_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      rd_cnt <= '0;
      rd_sel <= '0;
      o_intr <= 1'b0;
    end else begin
      state  <= state_nxt;
      o_intr <= rd_last;
      if (rd_en)   rd_cnt <= rd_cnt + 9'd1;
      if (rd_last) rd_sel <= rd_sel + 2'd1;
    end
  end

  // Leaving READ always passes through IDLE, giving a one-cycle gap between line reads.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (total_cnt >= THREE_LINES) state_nxt = READ;
      READ:    if (rd_cnt == 9'd511) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign o_pixel_data_valid = rd_en;
  assign o_pixel_data       = {buf_dat[rd_sel], buf_dat[rd_sel1], buf_dat[rd_sel2]};
endmodule

// File: tb/tb_image_control.sv
// Scoreboard bench for image_control: stimulus pushes expected windows, a negedge monitor pops them.
// The monitor also checks read-run length and the o_intr pulse at the end of each run.

module tb_image_control;
  logic        clk;
  logic        rst;
  logic [7:0]  pix;
  logic        pix_vld;
  logic [71:0] out_dat;
  logic        out_vld;
  logic        intr;

  int total = 0;
  int bad = 0;
  logic [71:0] q [$];
  int  run = 0;
  bit  aborted = 0;

  image_control dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_pixel_data       (pix),
    .i_pixel_data_valid (pix_vld),
    .o_pixel_data       (out_dat),
    .o_pixel_data_valid (out_vld),
    .o_intr             (intr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: compares every valid window and checks run length / interrupt on each run end.
  always @(negedge clk) begin
    logic [71:0] e;
    if (rst && run > 0) aborted = 1'b1;
    if (out_vld) begin
      run++;
      if (intr) chk("intr_during_valid", {71'd0, intr}, 72'd0);
      if (q.size() == 0) begin
        chk("window_unexpected", {71'd0, out_vld}, 72'd0);
      end else begin
        e = q.pop_front();
        chk("window", out_dat, e);
      end
    end else if (run > 0) begin
      if (aborted) begin
        chk("intr_after_abort", {71'd0, intr}, 72'd0);
      end else begin
        chk("run_length", 72'(run), 72'd512);
        chk("intr_pulse", {71'd0, intr}, 72'd1);
      end
      run = 0;
      aborted = 1'b0;
    end else if (intr) begin
      chk("intr_stray", {71'd0, intr}, 72'd0);
    end
  end

  task automatic write_pix(input logic [7:0] d);
    pix = d;
    pix_vld = 1'b1;
    @(posedge clk); #1;
    pix_vld = 1'b0;
  endtask

  // kind 0: constant value per line; kind 1: pixel = column index
  task automatic stream_line(input int kind, input logic [7:0] val, input bit gaps);
    for (int c = 0; c < 512; c++) begin
      if (gaps && $urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      write_pix(kind == 0 ? val : c[7:0]);
    end
  endtask

  task automatic push_const(input int n, input logic [71:0] w);
    for (int i = 0; i < n; i++) q.push_back(w);
  endtask

  task automatic push_cols();
    logic [7:0] a, b, d;
    for (int c = 0; c < 512; c++) begin
      a = c[7:0];
      b = 8'((c + 1) % 512);
      d = 8'((c + 2) % 512);
      q.push_back({a, b, d, a, b, d, a, b, d});
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pix_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("reset_valid", {71'd0, out_vld}, 72'd0);
      chk("reset_intr", {71'd0, intr}, 72'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_reset_valid", {71'd0, out_vld}, 72'd0);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || out_vld) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("drain_queue_empty", 72'(q.size()), 72'd0);
    @(posedge clk); #1;
  endtask

  task automatic scenario_const3();
    stream_line(0, 8'h10, 1'b0);
    stream_line(0, 8'h20, 1'b0);
    stream_line(0, 8'h30, 1'b0);
    push_const(512, 72'h101010_202020_303030);
    @(negedge clk);
    chk("valid_not_yet", {71'd0, out_vld}, 72'd0);
    @(negedge clk);
    chk("valid_rise", {71'd0, out_vld}, 72'd1);
  endtask

  initial begin
    rst = 1'b1;
    pix = 8'h00;
    pix_vld = 1'b0;

    do_reset();
    scenario_const3();
    drain();

    do_reset();
    for (int k = 0; k < 3; k++) stream_line(1, 8'h00, 1'b0);
    push_cols();
    drain();

    do_reset();
    for (int k = 0; k < 3; k++) stream_line(1, 8'h00, 1'b1);
    push_cols();
    drain();

    // Four lines back-to-back: the fourth fills while the first window set is read.
    do_reset();
    stream_line(0, 8'h10, 1'b0);
    stream_line(0, 8'h20, 1'b0);
    stream_line(0, 8'h30, 1'b0);
    push_const(512, 72'h101010_202020_303030);
    push_const(512, 72'h202020_303030_404040);
    stream_line(0, 8'h40, 1'b0);
    drain();

    // Reset after 100 read cycles, then a fresh stream must behave like a clean start.
    do_reset();
    stream_line(0, 8'h10, 1'b0);
    stream_line(0, 8'h20, 1'b0);
    stream_line(0, 8'h30, 1'b0);
    push_const(100, 72'h101010_202020_303030);
    repeat (100) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("valid_after_mid_reset", {71'd0, out_vld}, 72'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    scenario_const3();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
